// File: rtl/memory_stage_pkg.sv
// Shared encodings and helpers for the memory-access pipeline stage.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10,
    SzBad  = 2'b11
  } size_e;

  typedef enum logic {
    StIdle,
    StBus
  } state_e;

  localparam int unsigned TimeoutDefault = 255;

  // Little-endian lanes touched by an aligned access.
  function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] addr);
    case (sz)
      SzByte:  byte_en = 4'b0001 << addr;
      SzHalf:  byte_en = addr[1] ? 4'b1100 : 4'b0011;
      SzWord:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of the bus word and sign- or zero-extends it.
module load_align
  import memory_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  size_e       size,
  input  logic        unsignedLoad,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    // Halves are aligned, so the same byte shift serves both sub-word sizes.
    shifted = rdata >> {addr, 3'b000};
    case (size)
      SzByte:  data = {{24{~unsignedLoad & shifted[7]}}, shifted[7:0]};
      SzHalf:  data = {{16{~unsignedLoad & shifted[15]}}, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory-access stage: req/ack data-bus loads and stores with timeout,
// registering the MEM/WB fields consumed by write-back.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid,
  output logic        inReady,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  input  logic        memToRegIn,
  input  logic        regWriteIn,
  input  logic [4:0]  writeRegIn,
  input  logic [31:0] result,
  input  logic [31:0] storeData,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busBe,
  input  logic        busAck,
  input  logic [31:0] busRdata,
  output logic        wbValid,
  output logic        memToReg,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] readData,
  output logic [31:0] resultOut,
  output logic        fault
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q;
  size_e       sz, size_q;
  logic        accept, is_mem, bad, start_bus, ack_done, timed_out;
  logic [31:0] wdata_d, load_data;

  logic        bus_we_q, unsigned_q, is_load_q;
  logic [31:0] bus_addr_q, bus_wdata_q, p_result_q;
  logic [3:0]  bus_be_q;
  logic [1:0]  lane_q;
  logic        p_mem_to_reg_q, p_reg_write_q;
  logic [4:0]  p_write_reg_q;

  logic        wb_valid_q, fault_q, mem_to_reg_q, reg_write_q;
  logic [4:0]  write_reg_q;
  logic [31:0] read_data_q, result_q;

  assign sz        = size_e'(size);
  assign inReady   = (state_q == StIdle);
  assign accept    = inValid && inReady;
  assign is_mem    = memRead || memWrite;
  assign bad       = is_mem && ((memRead && memWrite) || (sz == SzBad) ||
                                (sz == SzHalf && result[0]) || (sz == SzWord && |result[1:0]));
  assign start_bus = accept && is_mem && !bad;
  assign ack_done  = (state_q == StBus) && busAck;
  assign timed_out = (state_q == StBus) && !busAck && (cnt_q == TimeoutLast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_bus) state_d = StBus;
      StBus:   if (ack_done || timed_out) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (sz)
      SzByte:  wdata_d = {4{storeData[7:0]}};
      SzHalf:  wdata_d = {2{storeData[15:0]}};
      default: wdata_d = storeData;
    endcase
  end

  load_align u_load_align (
    .rdata        (busRdata),
    .addr         (lane_q),
    .size         (size_q),
    .unsignedLoad (unsigned_q),
    .data         (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_bus)            cnt_q <= '0;
      else if (state_q == StBus) cnt_q <= cnt_q + 8'd1;
    end
  end

  // Bus request fields and the instruction's WB fields, held for the whole transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_be_q       <= '0;
      bus_we_q       <= 1'b0;
      lane_q         <= '0;
      size_q         <= SzByte;
      unsigned_q     <= 1'b0;
      is_load_q      <= 1'b0;
      p_mem_to_reg_q <= 1'b0;
      p_reg_write_q  <= 1'b0;
      p_write_reg_q  <= '0;
      p_result_q     <= '0;
    end else if (start_bus) begin
      bus_addr_q     <= {result[31:2], 2'b00};
      bus_wdata_q    <= wdata_d;
      bus_be_q       <= byte_en(sz, result[1:0]);
      bus_we_q       <= memWrite;
      lane_q         <= result[1:0];
      size_q         <= sz;
      unsigned_q     <= unsignedLoad;
      is_load_q      <= memRead;
      p_mem_to_reg_q <= memToRegIn;
      p_reg_write_q  <= regWriteIn;
      p_write_reg_q  <= writeRegIn;
      p_result_q     <= result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q   <= 1'b0;
      fault_q      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      read_data_q  <= '0;
      result_q     <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      if (accept && (!is_mem || bad)) begin
        wb_valid_q   <= 1'b1;
        fault_q      <= bad;
        mem_to_reg_q <= memToRegIn;
        reg_write_q  <= regWriteIn && !bad;
        write_reg_q  <= writeRegIn;
        result_q     <= result;
      end else if (ack_done || timed_out) begin
        wb_valid_q   <= 1'b1;
        fault_q      <= timed_out;
        mem_to_reg_q <= p_mem_to_reg_q;
        reg_write_q  <= p_reg_write_q && ack_done;
        write_reg_q  <= p_write_reg_q;
        result_q     <= p_result_q;
        if (ack_done) read_data_q <= is_load_q ? load_data : 32'd0;
      end
    end
  end

  assign busReq    = (state_q == StBus);
  assign busWe     = busReq && bus_we_q;
  assign busAddr   = bus_addr_q;
  assign busWdata  = bus_wdata_q;
  assign busBe     = bus_be_q;
  assign wbValid   = wb_valid_q;
  assign fault     = fault_q;
  assign memToReg  = mem_to_reg_q;
  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign readData  = read_data_q;
  assign resultOut = result_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a transaction-level model.
module tb_memory_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid = 1'b0, memRead = 1'b0, memWrite = 1'b0, unsignedLoad = 1'b0;
  logic        memToRegIn = 1'b0, regWriteIn = 1'b0, busAck = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [4:0]  writeRegIn = 5'd0;
  logic [31:0] result = 32'd0, storeData = 32'd0, busRdata = 32'd0;
  logic        inReady, busReq, busWe, wbValid, memToReg, regWrite, fault;
  logic [31:0] busAddr, busWdata, readData, resultOut;
  logic [3:0]  busBe;
  logic [4:0]  writeReg;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .memRead(memRead), .memWrite(memWrite), .size(size), .unsignedLoad(unsignedLoad),
    .memToRegIn(memToRegIn), .regWriteIn(regWriteIn), .writeRegIn(writeRegIn),
    .result(result), .storeData(storeData), .busReq(busReq), .busWe(busWe),
    .busAddr(busAddr), .busWdata(busWdata), .busBe(busBe), .busAck(busAck),
    .busRdata(busRdata), .wbValid(wbValid), .memToReg(memToReg), .regWrite(regWrite),
    .writeReg(writeReg), .readData(readData), .resultOut(resultOut), .fault(fault)
  );

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        uns, m2r, rw;
    logic [4:0]  wreg;
    logic [31:0] res, sd;
    int          wt;     // wait cycles before ack; >= TO means never ack
    bit          fix;
    logic [31:0] rv;
  } txn_t;

  int vectors = 0, errors = 0;
  bit checking = 0;

  // Expected values for the current cycle, plus the WB event due next cycle.
  bit          exp_ready = 1, exp_req = 0, exp_we = 0, exp_wb = 0, exp_fault = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_rd = 0, exp_res = 0;
  logic [3:0]  exp_be = 0;
  logic        exp_m2r = 0, exp_rw = 0;
  logic [4:0]  exp_wr = 0;
  bit          nxt_wb = 0, nxt_fault = 0;
  logic        nxt_m2r = 0, nxt_rw = 0;
  logic [4:0]  nxt_wr = 0;
  logic [31:0] nxt_rd = 0, nxt_res = 0;

  int          busy_cnt;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_fault(input logic rd, input logic wr, input logic [1:0] sz,
                                  input logic [31:0] a);
    if (!(rd || wr)) return 0;
    if (rd && wr) return 1;
    if (sz == 2'd3) return 1;
    if (sz == 2'd1 && (a % 2) != 0) return 1;
    if (sz == 2'd2 && (a % 4) != 0) return 1;
    return 0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] m;
    m = 4'((1 << nbytes(sz)) - 1);
    return m << (a % 4);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (nbytes(sz) == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (nbytes(sz) == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                             input logic uns, input logic [31:0] rdata);
    int n;
    logic [31:0] v, mask;
    n = nbytes(sz);
    if (n == 4) return rdata;
    v    = rdata >> (8 * (a % 4));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    exp_wb    = nxt_wb;
    exp_fault = nxt_fault;
    if (nxt_wb) begin
      exp_m2r = nxt_m2r;
      exp_rw  = nxt_rw;
      exp_wr  = nxt_wr;
      exp_rd  = nxt_rd;
      exp_res = nxt_res;
    end
    nxt_wb    = 0;
    nxt_fault = 0;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("inReady", inReady, exp_ready);
      chk("busReq", busReq, exp_req);
      if (exp_req) begin
        chk("busAddr", busAddr, exp_addr);
        chk("busBe", busBe, exp_be);
        chk("busWe", busWe, exp_we);
        if (exp_we) chk("busWdata", busWdata, exp_wdata);
      end
      chk("wbValid", wbValid, exp_wb);
      chk("fault", fault, exp_fault);
      chk("memToReg", memToReg, exp_m2r);
      chk("regWrite", regWrite, exp_rw);
      chk("writeReg", writeReg, exp_wr);
      chk("readData", readData, exp_rd);
      chk("resultOut", resultOut, exp_res);
    end
  end

  // Starts in a cycle where the stage is idle; returns in the WB cycle.
  task automatic run_txn(input txn_t t);
    bit mem, bad;
    int ncyc;
    mem = t.rd || t.wr;
    bad = is_fault(t.rd, t.wr, t.sz, t.res);
    busy_cnt = 0;
    inValid = 1; memRead = t.rd; memWrite = t.wr; size = t.sz; unsignedLoad = t.uns;
    memToRegIn = t.m2r; regWriteIn = t.rw; writeRegIn = t.wreg; result = t.res;
    storeData = t.sd; busRdata = $urandom; busAck = ($urandom_range(0, 3) == 0);
    exp_ready = 1; exp_req = 0;
    nxt_m2r = t.m2r; nxt_wr = t.wreg; nxt_res = t.res; nxt_rd = exp_rd;
    if (!mem || bad) begin
      nxt_wb = 1; nxt_fault = bad; nxt_rw = bad ? 1'b0 : t.rw;
      step();
      inValid = 0; busAck = 0;
      return;
    end
    step();
    exp_ready = 0; exp_req = 1; exp_we = t.wr;
    exp_addr  = t.res - (t.res % 4);
    exp_be    = model_be(t.sz, t.res);
    exp_wdata = model_wdata(t.sz, t.sd);
    ncyc = (t.wt < int'(TO)) ? t.wt + 1 : int'(TO);
    for (int i = 0; i < ncyc; i++) begin
      inValid  = $urandom_range(0, 1);
      busRdata = (t.fix && i == t.wt) ? t.rv : $urandom;
      busAck   = (i == t.wt);
      busy_cnt += int'(!inReady);
      if (i == 0) begin
        obs_addr = busAddr; obs_wdata = busWdata; obs_be = busBe; obs_we = busWe;
      end
      if (i == ncyc - 1) begin
        nxt_wb = 1;
        if (t.wt < int'(TO)) begin
          nxt_fault = 0; nxt_rw = t.rw;
          nxt_rd = t.rd ? model_load(t.sz, t.res, t.uns, busRdata) : 32'd0;
        end else begin
          nxt_fault = 1; nxt_rw = 0;
        end
      end
      step();
    end
    inValid = 0; busAck = 0; exp_ready = 1; exp_req = 0;
  endtask

  initial begin
    txn_t t;
    int op;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    checking = 1;
    #1;
    chk("rst_busAddr", busAddr, 32'd0);
    chk("rst_busWdata", busWdata, 32'd0);
    chk("rst_busBe", busBe, 4'd0);
    chk("rst_busWe", busWe, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // ALU pass-through
    t = '{rd: 0, wr: 0, sz: 2, uns: 0, m2r: 0, rw: 1, wreg: 5, res: 32'h1234_5678, sd: 0,
          wt: 0, fix: 0, rv: 0};
    run_txn(t);
    chk("alu_wbValid", wbValid, 1'b1);
    chk("alu_resultOut", resultOut, 32'h1234_5678);
    chk("alu_writeReg", writeReg, 5'd5);

    // signed byte load, lane 3, three wait states
    t = '{rd: 1, wr: 0, sz: 0, uns: 0, m2r: 1, rw: 1, wreg: 7, res: 32'h103, sd: 0,
          wt: 3, fix: 1, rv: 32'h80FF_FFFF};
    run_txn(t);
    chk("lb_readData", readData, 32'hFFFF_FF80);
    chk("lb_busBe", obs_be, 4'b1000);
    chk("lb_busy_cycles", busy_cnt, 4);

    // half store to upper half
    t = '{rd: 0, wr: 1, sz: 1, uns: 0, m2r: 0, rw: 0, wreg: 0, res: 32'h202,
          sd: 32'hABCD_1234, wt: 0, fix: 0, rv: 0};
    run_txn(t);
    chk("sh_busAddr", obs_addr, 32'h200);
    chk("sh_busBe", obs_be, 4'b1100);
    chk("sh_busWdata", obs_wdata, 32'h1234_1234);
    chk("sh_busWe", obs_we, 1'b1);
    chk("sh_readData", readData, 32'd0);

    // misaligned word load
    t = '{rd: 1, wr: 0, sz: 2, uns: 0, m2r: 1, rw: 1, wreg: 9, res: 32'h101, sd: 0,
          wt: 0, fix: 0, rv: 0};
    run_txn(t);
    chk("mis_fault", fault, 1'b1);
    chk("mis_regWrite", regWrite, 1'b0);
    chk("mis_busy_cycles", busy_cnt, 0);

    // no ack: timeout
    t = '{rd: 1, wr: 0, sz: 2, uns: 0, m2r: 1, rw: 1, wreg: 3, res: 32'h300, sd: 0,
          wt: TO, fix: 0, rv: 0};
    run_txn(t);
    chk("to_busy_cycles", busy_cnt, 4);
    chk("to_fault", fault, 1'b1);
    chk("to_wbValid", wbValid, 1'b1);
    chk("to_inReady", inReady, 1'b1);

    for (int n = 0; n < 300; n++) begin
      op    = $urandom_range(0, 19);
      t.rd  = (op >= 5 && op < 12) || op >= 18;
      t.wr  = (op >= 12);
      t.sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      t.uns = 1'($urandom_range(0, 1));
      t.m2r = 1'($urandom_range(0, 1));
      t.rw  = 1'($urandom_range(0, 1));
      t.wreg = 5'($urandom);
      t.res = $urandom;
      if ($urandom_range(0, 1) == 0) t.res = t.res & 32'hFFFF_FFFC;
      t.sd  = $urandom;
      t.wt  = $urandom_range(0, TO + 1);
      t.fix = 0;
      t.rv  = 0;
      run_txn(t);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
    end

    // reset while a load is waiting on the bus
    inValid = 1; memRead = 1; memWrite = 0; size = 2'd2; result = 32'h400;
    exp_ready = 1; exp_req = 0;
    step();
    inValid = 0; memRead = 0;
    exp_ready = 0; exp_req = 1; exp_we = 0; exp_addr = 32'h400; exp_be = 4'hF;
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busReq", busReq, 1'b0);
    chk("rst_mid_inReady", inReady, 1'b1);
    exp_ready = 1; exp_req = 0;
    exp_m2r = 0; exp_rw = 0; exp_wr = 0; exp_rd = 0; exp_res = 0;
    nxt_wb = 0; nxt_fault = 0;
    step();
    rst_n = 1'b1;
    repeat (TO + 2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
